// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I-subset core: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and the req/ack memory handshake.
package multicycle_ctrl_pkg;
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;
endpackage

module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output alu_op_e    alu_op,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic       retire,
   output logic       illegal
);
   localparam int unsigned OPW = 7;
   localparam logic [OPW-1:0] OP_LOAD  = 7'b0000011;
   localparam logic [OPW-1:0] OP_STORE = 7'b0100011;
   localparam logic [OPW-1:0] OP_RTYPE = 7'b0110011;
   localparam logic [OPW-1:0] OP_ITYPE = 7'b0010011;
   localparam logic [OPW-1:0] OP_BRNCH = 7'b1100011;
   localparam logic [OPW-1:0] OP_JAL   = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
   } state_e;

   state_e  state, state_next;
   alu_op_e alu_dec;
   logic    f3_ok;
   logic    mem_req_raw, mem_write_raw, ir_write_raw, pc_write_raw;
   logic    reg_write_raw, retire_raw, illegal_raw;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   // ALU operation from funct3; funct7b5 only selects SUB for R-type
   always_comb begin
      alu_dec = ALU_ADD;
      f3_ok   = 1'b1;
      case (funct3)
         3'b000:  alu_dec = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_dec = ALU_SLT;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         default: f3_ok   = 1'b0;
      endcase
   end

   // Immediate format follows the opcode, independent of state
   always_comb begin
      imm_src = 2'b00;
      case (opcode)
         OP_STORE: imm_src = 2'b01;
         OP_BRNCH: imm_src = 2'b10;
         OP_JAL:   imm_src = 2'b11;
         default:  imm_src = 2'b00;
      endcase
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_next    = state;
      mem_req_raw   = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      pc_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      retire_raw    = 1'b0;
      illegal_raw   = 1'b0;
      adr_src       = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = ALU_ADD;
      result_src    = 2'b00;
      unique case (state)
         S_FETCH: begin
            mem_req_raw = 1'b1;
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            if (mem_ack) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               state_next   = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = f3_ok ? S_EXECR : S_ILLEGAL;
               OP_ITYPE:          state_next = f3_ok ? S_EXECI : S_ILLEGAL;
               OP_BRNCH:          state_next = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
               OP_JAL:            state_next = S_JAL;
               default:           state_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req_raw = 1'b1;
            adr_src     = 1'b1;
            if (mem_ack) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            result_src    = 2'b01;
            reg_write_raw = 1'b1;
            retire_raw    = 1'b1;
            state_next    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_raw   = 1'b1;
            mem_write_raw = 1'b1;
            adr_src       = 1'b1;
            if (mem_ack) begin
               retire_raw = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXECR: begin
            alu_src_a  = 2'b10;
            alu_op     = alu_dec;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            alu_op     = alu_dec;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
            retire_raw    = 1'b1;
            state_next    = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a    = 2'b10;
            alu_op       = ALU_SUB;
            pc_write_raw = zero;
            retire_raw   = 1'b1;
            state_next   = S_FETCH;
         end
         S_JAL: begin
            alu_src_a    = 2'b01;
            alu_src_b    = 2'b10;
            pc_write_raw = 1'b1;
            state_next   = S_ALUWB;
         end
         S_ILLEGAL: begin
            illegal_raw = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Reset masks every side effect in the cycle it is asserted
   assign mem_req   = mem_req_raw   & ~rst;
   assign mem_write = mem_write_raw & ~rst;
   assign ir_write  = ir_write_raw  & ~rst;
   assign pc_write  = pc_write_raw  & ~rst;
   assign reg_write = reg_write_raw & ~rst;
   assign retire    = retire_raw    & ~rst;
   assign illegal   = illegal_raw   & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions checked against
// per-instruction expectations (cycle count, enable counts, ALU op) derived from the ISA rules.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam int NO_OP = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = OP_I;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ack = 1'b0;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
   alu_op_e    alu_op;

   int n_total = 0;
   int n_pass  = 0;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_write(mem_write),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_src(result_src), .imm_src(imm_src), .retire(retire), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         OP_LW, OP_SW, OP_JAL: return 1'b1;
         OP_R, OP_I:           return (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
         OP_BEQ:               return (f3 == 3'd0);
         default:              return 1'b0;
      endcase
   endfunction

   function automatic int base_cycles(input logic [6:0] op);
      case (op)
         OP_LW:   return 5;
         OP_BEQ:  return 3;
         default: return 4;
      endcase
   endfunction

   function automatic int exp_imm(input logic [6:0] op);
      case (op)
         OP_SW:   return 1;
         OP_BEQ:  return 2;
         OP_JAL:  return 3;
         default: return 0;
      endcase
   endfunction

   // ALU op seen while rs1 drives port A; jal never routes rs1
   function automatic int exp_op(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      if (op == OP_JAL) return NO_OP;
      if (op == OP_BEQ) return int'(ALU_SUB);
      if (op == OP_LW || op == OP_SW) return int'(ALU_ADD);
      case (f3)
         3'd2:    return int'(ALU_SLT);
         3'd6:    return int'(ALU_OR);
         3'd7:    return int'(ALU_AND);
         default: return (op == OP_R && f7) ? int'(ALU_SUB) : int'(ALU_ADD);
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; mem_ack = 1'b1;
      #1 check("rst_outs", int'({mem_req, mem_write, ir_write, pc_write, reg_write, retire, illegal}), 0);
      @(negedge clk);
      #1 check("rst_outs2", int'({mem_req, mem_write, ir_write, pc_write, reg_write, retire, illegal}), 0);
      rst = 1'b0; mem_ack = 1'b0;
   endtask

   // Run one instruction from FETCH with fw fetch waits and mw data waits
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input int fw, input int mw);
      int cyc = 0, fwl = fw, mwl = mw;
      int n_reg = 0, n_pc = 0, n_ir = 0, n_mw = 0, n_req = 0, n_dreq = 0;
      int n_fadr = 0, n_bad_mw = 0, n_ill = 0, n_ret = 0;
      int seen_op = NO_OP, seen_rs = -1;
      bit done = 1'b0, fetched = 1'b0;
      bit lgl  = is_legal(op, f3);
      bit is_mem = (op == OP_LW || op == OP_SW);
      opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
      while (!done && cyc < 64) begin
         @(negedge clk);
         if (mem_req) begin
            if (!fetched) begin mem_ack = (fwl == 0); if (fwl > 0) fwl--; end
            else          begin mem_ack = (mwl == 0); if (mwl > 0) mwl--; end
         end else begin
            mem_ack = 1'($urandom_range(0, 1));
         end
         #1;
         cyc++;
         if (cyc == 1) check("imm_src", int'(imm_src), exp_imm(op));
         if (mem_req) begin
            n_req++;
            if (fetched) n_dreq += int'(adr_src);
            else         n_fadr += int'(adr_src);
            if (!fetched && mem_ack) fetched = 1'b1;
         end
         n_reg    += int'(reg_write);
         n_pc     += int'(pc_write);
         n_ir     += int'(ir_write);
         n_mw     += int'(mem_write);
         n_bad_mw += int'(mem_write & ~mem_req);
         n_ill    += int'(illegal);
         n_ret    += int'(retire);
         if (alu_src_a == 2'b10) seen_op = int'(alu_op);
         if (reg_write) seen_rs = int'(result_src);
         if (retire || (!lgl && illegal)) done = 1'b1;
      end
      if (lgl) begin
         check("retired", int'(done), 1);
         check("cycles", cyc, base_cycles(op) + fw + (is_mem ? mw : 0));
         check("ir_write_cnt", n_ir, 1);
         check("pc_write_cnt", n_pc, 1 + ((op == OP_BEQ) ? int'(z) : 0) + ((op == OP_JAL) ? 1 : 0));
         check("reg_write_cnt", n_reg, (op == OP_SW || op == OP_BEQ) ? 0 : 1);
         check("mem_req_cnt", n_req, fw + 1 + (is_mem ? mw + 1 : 0));
         check("data_adr_cnt", n_dreq, is_mem ? mw + 1 : 0);
         check("fetch_adr", n_fadr, 0);
         check("mem_write_cnt", n_mw, (op == OP_SW) ? mw + 1 : 0);
         check("mem_write_no_req", n_bad_mw, 0);
         check("illegal_cnt", n_ill, 0);
         check("alu_op", seen_op, exp_op(op, f3, f7));
         if (op != OP_SW && op != OP_BEQ)
            check("wb_result_src", seen_rs, (op == OP_LW) ? 1 : 0);
      end else begin
         check("illegal_seen", int'(done), 1);
         check("illegal_retire", n_ret, 0);
         check("illegal_reg_write", n_reg, 0);
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            check("illegal_held", int'(illegal), 1);
            check("illegal_quiet", int'({mem_req, mem_write, ir_write, pc_write, reg_write, retire}), 0);
         end
         do_reset();
      end
   endtask

   initial begin
      int sel, fw, mw;
      logic [2:0] f3;
      do_reset();
      // addi, then funct7b5 ignored for I-type
      run_instr(OP_I, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
      // R-type op decode
      run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
      run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr(OP_R, 3'b010, 1'b0, 1'b0, 0, 0);
      run_instr(OP_R, 3'b110, 1'b1, 1'b0, 0, 0);
      run_instr(OP_R, 3'b111, 1'b0, 1'b0, 1, 0);
      run_instr(OP_R, 3'b001, 1'b0, 1'b0, 0, 0);
      // lw with 3 fetch waits and 2 read waits: 10 cycles
      run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 3, 2);
      run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 0);
      run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
      run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr(OP_BEQ, 3'b001, 1'b0, 1'b1, 0, 0);
      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1, 0);

      // Reset while a store waits for ack
      opcode = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
      @(negedge clk); mem_ack = 1'b1; #1;
      @(negedge clk); mem_ack = 1'b0; #1;
      @(negedge clk); #1;
      @(negedge clk); #1 check("sw_wait_mem_write", int'(mem_write), 1);
      @(negedge clk); rst = 1'b1; mem_ack = 1'b1;
      #1 check("rst_mid_mem_write", int'(mem_write), 0);
      check("rst_mid_retire", int'(retire), 0);
      check("rst_mid_enables", int'({pc_write, reg_write, ir_write, mem_req}), 0);
      @(negedge clk); rst = 1'b0; mem_ack = 1'b0;
      #1 check("rst_then_fetch", int'({mem_req, adr_src}), 2);

      // Random instruction mix with random memory latency
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 9));
         f3  = 3'($urandom_range(0, 7));
         fw  = int'($urandom_range(0, 3));
         mw  = int'($urandom_range(0, 3));
         case (sel)
            0, 1:    run_instr(OP_LW, f3, 1'($urandom), 1'($urandom), fw, mw);
            2:       run_instr(OP_SW, f3, 1'($urandom), 1'($urandom), fw, mw);
            3, 4:    run_instr(OP_R, f3, 1'($urandom), 1'($urandom), fw, mw);
            5, 6:    run_instr(OP_I, f3, 1'($urandom), 1'($urandom), fw, mw);
            7:       run_instr(OP_BEQ, ($urandom_range(0, 3) == 0) ? f3 : 3'b000,
                               1'($urandom), 1'($urandom), fw, mw);
            8:       run_instr(OP_JAL, f3, 1'($urandom), 1'($urandom), fw, mw);
            default: run_instr(7'($urandom) | 7'b0000100, f3, 1'($urandom), 1'($urandom), fw, mw);
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
